// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer, truncating toward zero.
// Sequential design with stb/ack handshakes; the mantissa is aligned one bit per cycle.
module float_to_int #(
  parameter logic [31:0] OVF_VALUE = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    UNPACK  = 3'd1,
    SPECIAL = 3'd2,
    CONVERT = 3'd3,
    PACK    = 3'd4,
    PUT_Z   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               in_ack_q, in_ack_d;
  logic               out_stb_q, out_stb_d;
  logic [31:0]        out_z_q, out_z_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        m_q, m_d;
  logic signed [9:0]  e_q, e_d;
  logic               s_q, s_d;
  logic [31:0]        z_q, z_d;

  // Two's-complement negation wraps, so a magnitude of 2^31 stays 0x80000000.
  function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] mag);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

  always_comb begin
    state_d   = state_q;
    in_ack_d  = in_ack_q;
    out_stb_d = out_stb_q;
    out_z_d   = out_z_q;
    a_d       = a_q;
    m_d       = m_q;
    e_d       = e_q;
    s_d       = s_q;
    z_d       = z_q;
    case (state_q)
      GET_A: begin
        in_ack_d = 1'b1;
        if (in_ack_q && input_a_stb) begin
          a_d      = input_a;
          in_ack_d = 1'b0;
          state_d  = UNPACK;
        end
      end
      UNPACK: begin
        m_d     = {1'b1, a_q[22:0], 8'd0};
        e_d     = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        s_d     = a_q[31];
        state_d = SPECIAL;
      end
      SPECIAL: begin
        // NaN/inf first, then |x| < 1, then magnitudes beyond 2^31 - 1.
        if (e_q == 10'sd128) begin
          z_d     = OVF_VALUE;
          state_d = PUT_Z;
        end else if (e_q < 10'sd0) begin
          z_d     = 32'd0;
          state_d = PUT_Z;
        end else if (e_q > 10'sd30) begin
          z_d     = OVF_VALUE;
          state_d = PUT_Z;
        end else begin
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (e_q < 10'sd31) begin
          m_d = m_q >> 1;
          e_d = e_q + 10'sd1;
        end else begin
          state_d = PACK;
        end
      end
      PACK: begin
        z_d     = apply_sign(s_q, m_q);
        state_d = PUT_Z;
      end
      PUT_Z: begin
        out_stb_d = 1'b1;
        out_z_d   = z_q;
        if (out_stb_q && output_z_ack) begin
          out_stb_d = 1'b0;
          state_d   = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= GET_A;
      in_ack_q  <= 1'b0;
      out_stb_q <= 1'b0;
      out_z_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      in_ack_q  <= in_ack_d;
      out_stb_q <= out_stb_d;
      out_z_q   <= out_z_d;
    end
  end

  // Working datapath registers; always rewritten before use.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    m_q <= m_d;
    e_q <= e_d;
    s_q <= s_d;
    z_q <= z_d;
  end

  assign input_a_ack  = in_ack_q;
  assign output_z_stb = out_stb_q;
  assign output_z     = out_z_q;

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed table, handshake/reset sequences,
// and random operands checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int n_chk = 0;
  int n_err = 0;

  float_to_int dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    int          lat;
  } vec_t;

  function automatic logic [31:0] ref_z(input logic [31:0] a);
    int     ex;
    longint mag;
    ex = int'(a[30:23]);
    if (ex == 255) return 32'h80000000;
    if (ex < 127) return 32'h0;
    if (ex - 127 > 30) return 32'h80000000;
    mag = longint'({1'b1, a[22:0]});
    if (ex >= 150) mag = mag * (longint'(1) << (ex - 150));
    else           mag = mag / (longint'(1) << (150 - ex));
    if (a[31]) mag = -mag;
    return mag[31:0];
  endfunction

  function automatic int ref_lat(input logic [31:0] a);
    int ex;
    ex = int'(a[30:23]);
    if (ex == 255 || ex < 127 || ex - 127 > 30) return 3;
    return 5 + (31 - (ex - 127));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timeout got none expected event", name);
  endtask

  // Called #1 after a posedge; returns #1 after the edge where output_z_stb is first seen high.
  task automatic start_and_wait(input logic [31:0] a, output logic [31:0] z, output int lat);
    bit ok;
    input_a     = a;
    input_a_stb = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (input_a_ack) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      timeout("accept");
      input_a_stb = 1'b0;
      z = 32'hx; lat = -1;
      return;
    end
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    ok = 0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (output_z_stb) begin ok = 1; break; end
    end
    if (!ok) begin
      timeout("output_stb");
      lat = -1;
    end
    z = output_z;
  endtask

  task automatic release_z();
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
  endtask

  task automatic run_vec(input logic [31:0] a, input logic [31:0] ez, input int elat, input int hold);
    logic [31:0] z;
    int          lat;
    start_and_wait(a, z, lat);
    check($sformatf("z(%h)", a), z, ez);
    check($sformatf("lat(%h)", a), lat, elat);
    repeat (hold) begin @(posedge clk); #1; end
    release_z();
  endtask

  initial begin
    vec_t        tbl [14];
    logic [31:0] z, ra;
    int          lat;
    bit          seen;

    tbl[0]  = '{32'h3F800000, 32'h00000001, 36};
    tbl[1]  = '{32'hC0200000, 32'hFFFFFFFE, 35};
    tbl[2]  = '{32'h3F000000, 32'h00000000, 3};
    tbl[3]  = '{32'h4B7FFFFF, 32'h00FFFFFF, 13};
    tbl[4]  = '{32'h4EFFFFFF, 32'h7FFFFF80, 6};
    tbl[5]  = '{32'h4F000000, 32'h80000000, 3};
    tbl[6]  = '{32'h7FC00000, 32'h80000000, 3};
    tbl[7]  = '{32'hFF800000, 32'h80000000, 3};
    tbl[8]  = '{32'h80000000, 32'h00000000, 3};
    tbl[9]  = '{32'h40000000, 32'h00000002, 35};
    tbl[10] = '{32'hBF800000, 32'hFFFFFFFF, 36};
    tbl[11] = '{32'h7F7FFFFF, 32'h80000000, 3};
    tbl[12] = '{32'h00000001, 32'h00000000, 3};
    tbl[13] = '{32'hCEFFFFFF, 32'h80000080, 6};

    rst = 1'b1; input_a = 32'h0; input_a_stb = 1'b0; output_z_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ack", {31'd0, input_a_ack}, 32'd0);
    check("reset_out_stb", {31'd0, output_z_stb}, 32'd0);
    check("reset_out_z", output_z, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_in_ack", {31'd0, input_a_ack}, 32'd1);

    foreach (tbl[i]) run_vec(tbl[i].a, tbl[i].z, tbl[i].lat, 0);

    // Back-pressure: result held while downstream stalls.
    start_and_wait(32'h3F800000, z, lat);
    check("bp_lat", lat, 36);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_stb", {31'd0, output_z_stb}, 32'd1);
      check("bp_z", output_z, 32'h00000001);
      check("bp_in_ack", {31'd0, input_a_ack}, 32'd0);
    end
    release_z();
    check("bp_stb_low", {31'd0, output_z_stb}, 32'd0);
    check("bp_in_ack_low", {31'd0, input_a_ack}, 32'd0);
    @(posedge clk); #1;
    check("bp_in_ack_high", {31'd0, input_a_ack}, 32'd1);

    // Reset mid-conversion aborts the operand.
    input_a = 32'h3F800000; input_a_stb = 1'b1;
    seen = 0;
    for (int i = 0; i < 100 && !input_a_ack; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_stb", {31'd0, output_z_stb}, 32'd0);
    check("rst_mid_in_ack", {31'd0, input_a_ack}, 32'd0);
    check("rst_mid_z", output_z, 32'd0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (output_z_stb) seen = 1;
    end
    check("rst_no_result", {31'd0, seen}, 32'd0);
    run_vec(32'hC0200000, 32'hFFFFFFFE, 35, 0);

    // Random operands, biased toward the convertible exponent range.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      if ($urandom_range(3) != 0) ra[30:23] = 8'($urandom_range(160, 120));
      run_vec(ra, ref_z(ra), ref_lat(ra), $urandom_range(3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
